// File: rtl/sprite_move_fsm_if.sv
// Command/position bundle between the sprite movement sequencer (slave side)
// and the sprite drawer plus request sources (master side).
interface sprite_move_fsm_if;
  logic       move_right;
  logic       move_left;
  logic       move_down;
  logic       move_up;
  logic       complete;
  logic [7:0] posx;
  logic [6:0] posy;
  logic       draw;
  logic       clear;
  logic       shift_h;
  logic       shift_v;
  logic       load;
  logic [6:0] shift_amount;
  logic [7:0] load_x;
  logic [6:0] load_y;
  logic       busy;
  logic       move_done;

  modport master (
    output move_right, move_left, move_down, move_up, complete, posx, posy,
    input  draw, clear, shift_h, shift_v, load, shift_amount,
    input  load_x, load_y, busy, move_done
  );

  modport slave (
    input  move_right, move_left, move_down, move_up, complete, posx, posy,
    output draw, clear, shift_h, shift_v, load, shift_amount,
    output load_x, load_y, busy, move_done
  );
endinterface

// File: rtl/sprite_move_fsm.sv
// Sprite movement sequencer: on a move tick it erases the sprite, loads a
// clamped target position into the drawer and repaints the sprite there.
module sprite_move_fsm #(
  parameter int STEP     = 4,
  parameter int MOVE_DIV = 833333,
  parameter int X_MAX    = 144,
  parameter int Y_MAX    = 104
) (
  input logic              clk,
  input logic              reset,
  sprite_move_fsm_if.slave bus
);

  localparam int             TW        = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(MOVE_DIV - 1);
  localparam logic [8:0]     STEP9     = 9'(STEP);
  localparam logic [8:0]     XMAX9     = 9'(X_MAX);
  localparam logic [8:0]     YMAX9     = 9'(Y_MAX);
  localparam logic [7:0]     XMAX8     = 8'(X_MAX);
  localparam logic [6:0]     YMAX7     = 7'(Y_MAX);

  typedef enum logic [2:0] {
    RESYNC = 3'd0,
    IDLE   = 3'd1,
    ERASE  = 3'd2,
    LOAD   = 3'd3,
    PAINT  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state_r;
  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;
  logic [7:0]    pix_cnt_r;

  logic [8:0]    right_s;
  logic [8:0]    left_s;
  logic [8:0]    down_s;
  logic [8:0]    up_s;
  logic [7:0]    tgt_x_s;
  logic [6:0]    tgt_y_s;
  logic          any_req_s;

  logic          draw_r;
  logic          clear_r;
  logic          shift_h_r;
  logic          shift_v_r;
  logic          load_r;
  logic [7:0]    load_x_r;
  logic [6:0]    load_y_r;
  logic          busy_r;
  logic          move_done_r;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign any_req_s = bus.move_right | bus.move_left | bus.move_down | bus.move_up;

  // Free-running move-opportunity divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Candidate target: one axis only; subtraction underflow shows up in the high bits.
  always_comb begin
    right_s = {1'b0, bus.posx} + STEP9;
    left_s  = {1'b0, bus.posx} - STEP9;
    down_s  = {2'b00, bus.posy} + STEP9;
    up_s    = {2'b00, bus.posy} - STEP9;
    tgt_x_s = bus.posx;
    tgt_y_s = bus.posy;
    if (bus.move_right) begin
      tgt_x_s = (right_s > XMAX9) ? XMAX8 : right_s[7:0];
    end else if (bus.move_left) begin
      tgt_x_s = left_s[8] ? 8'd0 : left_s[7:0];
    end else if (bus.move_down) begin
      tgt_y_s = (down_s > YMAX9) ? YMAX7 : down_s[6:0];
    end else if (bus.move_up) begin
      tgt_y_s = (up_s[8:7] != 2'b00) ? 7'd0 : up_s[6:0];
    end else begin
      tgt_x_s = bus.posx;
      tgt_y_s = bus.posy;
    end
  end

  // Sequencer; every output is set for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= RESYNC;
      pix_cnt_r   <= 8'd0;
      load_x_r    <= 8'd0;
      load_y_r    <= 7'd0;
      draw_r      <= 1'b0;
      clear_r     <= 1'b0;
      shift_h_r   <= 1'b0;
      shift_v_r   <= 1'b0;
      load_r      <= 1'b0;
      busy_r      <= 1'b1;
      move_done_r <= 1'b0;
    end else begin
      shift_v_r <= 1'b0;
      case (state_r)
        RESYNC: begin
          if (bus.complete) begin
            state_r <= IDLE;
            draw_r  <= 1'b0;
            clear_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= RESYNC;
            draw_r  <= 1'b1;
            clear_r <= 1'b1;
          end
        end
        IDLE: begin
          if (tick_s && any_req_s) begin
            state_r   <= ERASE;
            load_x_r  <= tgt_x_s;
            load_y_r  <= tgt_y_s;
            pix_cnt_r <= 8'd0;
            draw_r    <= 1'b1;
            clear_r   <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ERASE: begin
          if (pix_cnt_r == 8'd255) begin
            state_r   <= LOAD;
            pix_cnt_r <= 8'd0;
            clear_r   <= 1'b0;
            load_r    <= 1'b1;
          end else begin
            pix_cnt_r <= pix_cnt_r + 8'd1;
          end
        end
        LOAD: begin
          state_r   <= PAINT;
          pix_cnt_r <= 8'd0;
          load_r    <= 1'b0;
          shift_h_r <= 1'b1;
        end
        PAINT: begin
          if (pix_cnt_r == 8'd255) begin
            state_r     <= DONE;
            pix_cnt_r   <= 8'd0;
            draw_r      <= 1'b0;
            shift_h_r   <= 1'b0;
            move_done_r <= 1'b1;
          end else begin
            pix_cnt_r <= pix_cnt_r + 8'd1;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          move_done_r <= 1'b0;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= RESYNC;
          pix_cnt_r   <= 8'd0;
          draw_r      <= 1'b0;
          clear_r     <= 1'b0;
          shift_h_r   <= 1'b0;
          load_r      <= 1'b0;
          busy_r      <= 1'b1;
          move_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.draw         = draw_r;
  assign bus.clear        = clear_r;
  assign bus.shift_h      = shift_h_r;
  assign bus.shift_v      = shift_v_r;
  assign bus.load         = load_r;
  assign bus.shift_amount = 7'd0;
  assign bus.load_x       = load_x_r;
  assign bus.load_y       = load_y_r;
  assign bus.busy         = busy_r;
  assign bus.move_done    = move_done_r;

endmodule

// File: tb/tb_sprite_move_fsm.sv
// Randomised bench for sprite_move_fsm against a timeline model of a move:
// the model tracks cycles since acceptance and derives the expected strobes.
module tb_sprite_move_fsm;
  localparam int STEP = 4, MOVE_DIV = 4, X_MAX = 144, Y_MAX = 104;
  localparam int K_RST = 0, K_CLR = 1, K_IDLE = 2, K_MOVE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sprite_move_fsm_if bus();

  sprite_move_fsm #(.STEP(STEP), .MOVE_DIV(MOVE_DIV), .X_MAX(X_MAX), .Y_MAX(Y_MAX))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_kind, m_d, m_tcnt, m_lx, m_ly;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void target(input int px, input int py, input logic [3:0] req,
                                 output int nx, output int ny);
    nx = px; ny = py;
    if (req[3])      nx = (px + STEP > X_MAX) ? X_MAX : px + STEP;
    else if (req[2]) nx = (px < STEP) ? 0 : px - STEP;
    else if (req[1]) ny = (py + STEP > Y_MAX) ? Y_MAX : py + STEP;
    else if (req[0]) ny = (py < STEP) ? 0 : py - STEP;
  endfunction

  function automatic logic [3:0] cur_req();
    return {bus.move_right, bus.move_left, bus.move_down, bus.move_up};
  endfunction

  task automatic set_req(input logic [3:0] r);
    {bus.move_right, bus.move_left, bus.move_down, bus.move_up} = r;
  endtask

  task automatic model_edge();
    bit tick;
    tick   = (m_tcnt == MOVE_DIV - 1);
    m_tcnt = (m_tcnt + 1) % MOVE_DIV;
    case (m_kind)
      K_RST, K_CLR: m_kind = bus.complete ? K_IDLE : K_CLR;
      K_IDLE: if (tick && cur_req() != 4'd0) begin
        target(int'(bus.posx), int'(bus.posy), cur_req(), m_lx, m_ly);
        m_kind = K_MOVE;
        m_d    = 0;
      end
      K_MOVE: begin
        m_d++;
        if (m_d == 514) m_kind = K_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [13:0] e;
    int n;
    // {draw, clear, shift_h, shift_v, load, busy, move_done, shift_amount}
    case (m_kind)
      K_RST:   e = {7'b0000010, 7'd0};
      K_CLR:   e = {7'b1100010, 7'd0};
      K_IDLE:  e = {7'b0000000, 7'd0};
      default: begin
        if (m_d < 256)       e = {7'b1100010, 7'd0};
        else if (m_d == 256) e = {7'b1000110, 7'd0};
        else if (m_d <= 512) e = {7'b1010010, 7'd0};
        else                 e = {7'b0000011, 7'd0};
      end
    endcase
    check("outputs", {bus.draw, bus.clear, bus.shift_h, bus.shift_v, bus.load,
                      bus.busy, bus.move_done, bus.shift_amount}, e);
    check("load_xy", {bus.load_x, bus.load_y}, {8'(m_lx), 7'(m_ly)});
    n = int'(bus.clear) + int'(bus.shift_h) + int'(bus.shift_v) + int'(bus.load);
    check("strobe_excl", ((n <= 1) && (n == 0 || bus.draw)) ? 1 : 0, 1);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic cmp);
    reset = 1'b1;
    bus.complete = cmp;
    m_kind = K_RST; m_d = 0; m_tcnt = 0; m_lx = 0; m_ly = 0;
    #1;
    compare_all();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_accept(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3 * MOVE_DIV + 2; i++) begin
      step();
      if (m_kind == K_MOVE && m_d == 0) begin ok = 1; break; end
    end
    check({tag, "_accept"}, ok, 1);
  endtask

  task automatic do_move(input string tag, input int px, input int py,
                         input logic [3:0] req, input int ex, input int ey);
    int n_clr = 0, n_sh = 0, done_at = 0, cyc = 1, lx = -1, ly = -1;
    bus.posx = 8'(px);
    bus.posy = 7'(py);
    set_req(req);
    wait_accept(tag);
    for (int k = 0; k < 600; k++) begin
      if (bus.clear) n_clr++;
      if (bus.shift_h) n_sh++;
      if (bus.load) begin lx = int'(bus.load_x); ly = int'(bus.load_y); end
      if (bus.move_done) begin done_at = cyc; break; end
      step();
      cyc++;
    end
    set_req(4'd0);
    check({tag, "_erase"}, n_clr, 256);
    check({tag, "_paint"}, n_sh, 256);
    check({tag, "_latency"}, done_at, 514);
    check({tag, "_load_x"}, lx, ex);
    check({tag, "_load_y"}, ly, ey);
    step();
    step();
  endtask

  initial begin
    int nc, nd, ex, ey, px, py;
    logic [3:0] rq;
    bit ok;
    set_req(4'd0);
    bus.complete = 1'b0;
    bus.posx = 8'd0;
    bus.posy = 7'd0;
    @(negedge clk);

    // Resync with a few clear cycles, then fast resync
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step();
    bus.complete = 1'b1;
    step();
    check("resync_idle", bus.busy, 0);
    do_reset(1'b1);
    step();
    check("fast_resync_busy", bus.busy, 0);
    check("fast_resync_clear", bus.clear, 0);

    do_move("right72", 72, 52, 4'b1000, 76, 52);
    do_move("left2", 2, 50, 4'b0100, 0, 50);
    do_move("right142", 142, 50, 4'b1000, 144, 50);
    do_move("right_edge", 144, 50, 4'b1000, 144, 50);
    do_move("down103", 80, 103, 4'b0010, 80, 104);
    do_move("up2", 80, 2, 4'b0001, 80, 0);
    do_move("right_up", 10, 20, 4'b1001, 14, 20);

    // Two-cycle request pulse that misses the tick
    check("pulse_idle", bus.busy, 0);
    for (int i = 0; i < MOVE_DIV + 1 && m_tcnt != 0; i++) step();
    set_req(4'b1000);
    step();
    step();
    set_req(4'd0);
    for (int i = 0; i < 6; i++) step();
    check("pulse_busy", bus.busy, 0);

    // Reset in PAINT cycle 100, drawer pointer not at zero for 156 cycles
    bus.posx = 8'd40;
    bus.posy = 7'd40;
    set_req(4'b0010);
    wait_accept("mid");
    set_req(4'd0);
    ok = 0;
    nd = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.move_done) nd++;
      if (m_d == 357) begin ok = 1; break; end
      step();
    end
    check("mid_reach_paint", ok, 1);
    check("mid_in_paint", bus.shift_h, 1);
    do_reset(1'b0);
    nc = 0;
    for (int i = 0; i < 156; i++) begin
      step();
      if (bus.clear && bus.draw) nc++;
      if (bus.move_done) nd++;
    end
    bus.complete = 1'b1;
    step();
    check("mid_clear_cycles", nc, 156);
    check("mid_no_done", nd + int'(bus.move_done), 0);
    check("mid_idle", bus.busy, 0);

    // Random complete moves
    for (int t = 0; t < 8; t++) begin
      px = $urandom_range(0, 255);
      py = $urandom_range(0, 127);
      rq = 4'($urandom_range(1, 15));
      target(px, py, rq, ex, ey);
      do_move("rand", px, py, rq, ex, ey);
    end

    // Free-running random requests and positions against the timeline model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) set_req(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        bus.posx = 8'($urandom_range(0, 255));
        bus.posy = 7'($urandom_range(0, 127));
      end
      bus.complete = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sprite_move_fsm.md
SPRITE_MOVE_FSM -- requirements
Module: sprite_move_fsm

Interface
REQ-001 SHALL have parameter STEP, default 4, giving pixels moved per accepted request.
REQ-002 SHALL have parameter MOVE_DIV, default 833333, giving clk cycles between move opportunities.
REQ-003 SHALL have parameter X_MAX, default 144, giving the largest legal sprite x (160-16).
REQ-004 SHALL have parameter Y_MAX, default 104, giving the largest legal sprite y (120-16).
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports move_right, move_left, move_down, move_up  in  1 each  level move requests.
REQ-008 SHALL have port complete  in  1  the sprite drawer's pointer-at-zero flag.
REQ-009 SHALL have ports posx  in  8  and posy  in  7  holding the sprite drawer's current position.
REQ-010 SHALL have ports draw, clear, shift_h, shift_v, load  out  1 each  the sprite drawer's command strobes.
REQ-011 SHALL have port shift_amount  out  7  which is tied to 0.
REQ-012 SHALL have ports load_x  out  8  and load_y  out  7  giving the target position.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port move_done  out  1  a one-cycle pulse when a move completes.

Function
REQ-015 SHALL implement the states RESYNC, IDLE, ERASE, LOAD, PAINT and DONE.
REQ-016 SHALL keep a free-running tick counter that counts 0..MOVE_DIV-1 and wraps, with tick high when the count is MOVE_DIV-1.
REQ-017 In IDLE, all strobes SHALL be 0; on tick with any request, SHALL latch target and go to ERASE; otherwise SHALL stay in IDLE.
REQ-018 Request priority SHALL be right > left > down > up, moving only one axis per move; the other axis target SHALL equal the current position.
REQ-019 Target arithmetic SHALL use 9-bit intermediates: right gives min(posx+STEP, X_MAX); left gives posx<STEP ? 0 : posx-STEP; down gives min(posy+STEP, Y_MAX); up gives posy<STEP ? 0 : posy-STEP.
REQ-020 When the sprite is already at the clamp edge, the move SHALL still run the full sequence, repainting in place.
REQ-021 ERASE SHALL assert draw=1 and clear=1 for exactly 256 cycles, counted by an internal 8-bit counter, then go to LOAD.
REQ-022 LOAD SHALL assert draw=1 and load=1 (clear, shift_h and shift_v 0) for exactly 1 cycle, with load_x/load_y equal to the latched target, then go to PAINT.
REQ-023 PAINT SHALL assert draw=1 and shift_h=1 for exactly 256 cycles, then go to DONE.
REQ-024 DONE SHALL pulse move_done for 1 cycle with all strobes 0, then return to IDLE.
REQ-025 Latency from the accepting tick edge to move_done SHALL be 514 cycles; the next move SHALL be accepted no earlier than the next tick after IDLE is re-entered.
REQ-026 Requests arriving outside IDLE, or in IDLE without tick, SHALL be ignored and not queued.
REQ-027 At most one command strobe besides draw SHALL be high in any cycle.
REQ-028 Outputs SHALL be registered and stable for the whole clk period, so the downstream negedge sampler sees settled values.
REQ-029 load_x/load_y SHALL hold the last latched target outside LOAD.

Reset
REQ-030 Asserting reset SHALL immediately force state RESYNC, clear the tick and pixel counters, set load_x/load_y to 0, drive all strobes and move_done to 0, and set busy=1.
REQ-031 After reset release, RESYNC SHALL assert draw=1 and clear=1 each cycle until complete=1 is sampled; on that edge it SHALL drop the strobes and go to IDLE.
REQ-032 If complete=1 is sampled in the first RESYNC cycle, the block SHALL reach IDLE with no clear cycles.
REQ-033 Reset asserted mid-ERASE or mid-PAINT SHALL abandon the move and SHALL NOT produce move_done.

Verification
REQ-034 Verify MOVE_DIV=4, posx=72, posy=52, move_right held: ERASE 256 cycles -> LOAD with load_x=76, load_y=52 -> PAINT 256 cycles -> move_done 514 cycles after acceptance.
REQ-035 Verify posx=2 with move_left: load_x=0. Verify posx=142 with move_right: load_x=144. Verify posy=103 with move_down: load_y=104.
REQ-036 Verify move_right and move_up both high, posx=10, posy=20: load_x=14, load_y=20.
REQ-037 Verify reset during PAINT cycle 100 while complete=0 for 156 cycles: draw+clear held 156 cycles, then IDLE, with no move_done.
REQ-038 Verify a request pulse lasting 2 cycles that misses tick: no move, busy stays 0.
REQ-039 Verify, by assertion over all scenarios, that no two of clear, shift_h, shift_v and load are ever high together, and that none of them is high without draw.
